muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: none; latency and op codes come from the shared header.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request; accepted only in IDLE.
REQ-005 op  input  6  ALU_OP_MUL/MULU/MUH/MUHU/DIV/DIVU/MOD/MODU code; sampled on acceptance.
REQ-006 a  input  32  operand A (multiplicand/dividend); sampled on acceptance.
REQ-007 b  input  32  operand B (multiplier/divisor); sampled on acceptance.
REQ-008 flush  input  1  synchronous abort (pipeline exception/branch kill).
REQ-009 busy  output  1  high from the cycle after acceptance until done is high.
REQ-010 done  output  1  one-cycle pulse; result valid.
REQ-011 result  output  32  selected 32-bit result; held until next acceptance.
REQ-012 div_by_zero  output  1  valid with done; high for a divide-class op with b == 0.

Function
REQ-013 FSM states: IDLE, CALC, FIX, DONE.
REQ-014 IDLE -> CALC on start with supported op and flush low; operands are latched and a 5-bit step counter is cleared.
REQ-015 start with an unsupported op code: ignored, FSM stays IDLE, no done.
REQ-016 start while busy: ignored, no effect on the in-flight operation.
REQ-017 CALC: exactly 32 cycles, one bit per cycle.
- Multiply: radix-2 shift-add on magnitudes, 64-bit product.
- Divide: restoring, 33-bit partial remainder.
- CALC -> FIX when counter == 31 (wrap to 0).
REQ-018 Signed ops (MUL, MUH, DIV, MOD) operate on magnitudes.
- Sign fix applied in FIX by two's-complement negation.
- Product sign = a[31]^b[31]; quotient sign = a[31]^b[31]; remainder sign = a[31].
- Unsigned ops skip negation.
REQ-019 Result selection:
- MUL/MULU = product[31:0]; MUH/MUHU = product[63:32].
- DIV/DIVU = quotient; MOD/MODU = remainder.
REQ-020 FIX -> DONE after one cycle; DONE asserts done for one cycle, then -> IDLE.
REQ-021 Latency: done is high exactly 34 cycles after the acceptance edge (MDU_LATENCY = 34), independent of operand values.
REQ-022 Divide by zero (b == 0, divide-class):
- Full latency preserved.
- quotient = 32'hFFFFFFFF, remainder = a; div_by_zero = 1 with done.
REQ-023 Signed 32'h80000000 / 32'hFFFFFFFF: quotient 32'h80000000, remainder 0, no flag.
REQ-024 div_by_zero is 0 for multiply ops and is held with result.
REQ-025 flush high in any state:
- FSM -> IDLE next edge; no done for the aborted op.
- result and div_by_zero keep prior values.
- flush has priority over start in the same cycle.
REQ-026 A new start in the same cycle done is high is ignored (FSM not IDLE); earliest re-acceptance is the following cycle.

Reset
REQ-027 On rst_n low, immediately and independent of clk: FSM = IDLE, busy = 0, done = 0, result = 0, div_by_zero = 0, counter = 0, datapath registers = 0.
REQ-028 Reset asserted mid-operation discards it; no done follows reset release.

Structure
REQ-029 ALU_OP_* codes and MDU_LATENCY live in the shared common header; FSM state encodings stay local to the module.
REQ-030 Single module; no sub-module. Multiply and divide share the 64-bit shift register and the 33-bit adder/subtractor.

Verification
REQ-031 MUL a=32'hFFFFFFFE (-2), b=3 -> after 34 cycles done=1, result=32'hFFFFFFFA; MUH same operands -> 32'hFFFFFFFF.
REQ-032 MULU a=b=32'hFFFFFFFF -> MULU result 32'h00000001; MUHU result 32'hFFFFFFFE.
REQ-033 DIV a=-7 (32'hFFFFFFF9), b=2 -> result 32'hFFFFFFFD; MOD same operands -> 32'hFFFFFFFF; DIVU 100/7 -> 14, MODU -> 2.
REQ-034 DIVU a=5, b=0 -> done at cycle 34, result 32'hFFFFFFFF, div_by_zero=1; MODU a=5, b=0 -> result 5, div_by_zero=1.
REQ-035 Start MUL, assert flush at cycle 10 -> busy drops next cycle, no done within 40 cycles; a new start is then accepted normally. Also: start pulsed while busy -> ignored, original result unchanged.
REQ-036 rst_n low at cycle 20 of a DIV -> all outputs 0 immediately; no done after release.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// ----------------------------------------------------------------------------
// muldiv_unit_pkg
// Shared definitions for the multiply/divide unit: ALU op codes understood by
// the unit, the fixed issue-to-done latency, and an op decoder that splits an
// op code into the control bits the datapath needs.
// ----------------------------------------------------------------------------
package muldiv_unit_pkg;

    localparam logic [5:0] ALU_OP_MUL  = 6'h18;
    localparam logic [5:0] ALU_OP_MULU = 6'h19;
    localparam logic [5:0] ALU_OP_MUH  = 6'h1A;
    localparam logic [5:0] ALU_OP_MUHU = 6'h1B;
    localparam logic [5:0] ALU_OP_DIV  = 6'h1C;
    localparam logic [5:0] ALU_OP_DIVU = 6'h1D;
    localparam logic [5:0] ALU_OP_MOD  = 6'h1E;
    localparam logic [5:0] ALU_OP_MODU = 6'h1F;

    // Cycles from the accepting clock edge to the edge that raises done.
    localparam int MDU_LATENCY = 34;

    // sel_hi picks the upper half of the shared register at the end:
    // product[63:32] for multiplies, the remainder for divides.
    typedef struct packed {
        logic valid;
        logic is_div;
        logic is_signed;
        logic sel_hi;
    } op_info_t;

    function automatic op_info_t decode_op(input logic [5:0] op);
        op_info_t info;
        info = '0;
        case (op)
            ALU_OP_MUL:  info = '{valid: 1'b1, is_div: 1'b0, is_signed: 1'b1, sel_hi: 1'b0};
            ALU_OP_MULU: info = '{valid: 1'b1, is_div: 1'b0, is_signed: 1'b0, sel_hi: 1'b0};
            ALU_OP_MUH:  info = '{valid: 1'b1, is_div: 1'b0, is_signed: 1'b1, sel_hi: 1'b1};
            ALU_OP_MUHU: info = '{valid: 1'b1, is_div: 1'b0, is_signed: 1'b0, sel_hi: 1'b1};
            ALU_OP_DIV:  info = '{valid: 1'b1, is_div: 1'b1, is_signed: 1'b1, sel_hi: 1'b0};
            ALU_OP_DIVU: info = '{valid: 1'b1, is_div: 1'b1, is_signed: 1'b0, sel_hi: 1'b0};
            ALU_OP_MOD:  info = '{valid: 1'b1, is_div: 1'b1, is_signed: 1'b1, sel_hi: 1'b1};
            ALU_OP_MODU: info = '{valid: 1'b1, is_div: 1'b1, is_signed: 1'b0, sel_hi: 1'b1};
            default:     info = '0;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// ----------------------------------------------------------------------------
// muldiv_unit
// Iterative 32-bit multiply/divide unit. One bit per cycle: radix-2 shift-add
// multiply and restoring divide, both on operand magnitudes, sharing a 64-bit
// shift register and one 33-bit adder/subtractor. Signs are fixed up in a
// single cycle at the end. Fixed latency of MDU_LATENCY cycles.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request, accepted only when idle
//   op           ALU_OP_* code, sampled on acceptance
//   a, b         operands (multiplicand/dividend, multiplier/divisor)
//   flush        synchronous abort of the in-flight operation
//   busy         high from the cycle after acceptance until done
//   done         one-cycle result-valid pulse
//   result       selected 32-bit result, held until the next completion
//   div_by_zero  divide-class op with b == 0, valid with done and held
// ----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [5:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    // FIX and DONE each take one cycle; the rest of the latency is CALC.
    localparam int CALC_STEPS = MDU_LATENCY - 2;
    localparam logic [4:0] LAST_STEP = 5'(CALC_STEPS - 1);

    state_t      state;
    logic [4:0]  step_cnt;
    logic [63:0] acc;        // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
    logic [31:0] opb;        // mul: multiplicand magnitude; div: divisor magnitude
    logic        is_div_q;
    logic        sel_hi_q;
    logic        neg_q;
    logic        dbz_q;

    // ---------------------------------------------------------------- decode
    op_info_t    dec;
    logic        a_neg;
    logic        b_neg;
    logic        b_zero;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        neg_next;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        neg_next = 1'b0;
        dec      = decode_op(op);
        a_neg    = dec.is_signed & a[31];
        b_neg    = dec.is_signed & b[31];
        b_zero   = (b == 32'd0);
        mag_a    = a_neg ? 32'(-a) : a;
        mag_b    = b_neg ? 32'(-b) : b;
        if (dec.is_signed) begin
            if (!dec.is_div)
                neg_next = a[31] ^ b[31];
            else if (dec.sel_hi)
                neg_next = a[31];
            else
                // Divide by zero returns all-ones for the quotient regardless
                // of operand signs, so it must not be negated.
                neg_next = (a[31] ^ b[31]) & ~b_zero;
        end
    end

    // ------------------------------------------------------- shared adder
    // Multiply adds the multiplicand to the upper half. Divide subtracts the
    // divisor from the shifted 33-bit partial remainder as x + ~y + 1, so the
    // carry out of bit 33 means "no borrow" (trial subtraction succeeded).
    logic [32:0] add_x;
    logic [32:0] add_y;
    logic        add_cin;
    logic [33:0] add_sum;
    logic [63:0] acc_step;

    always_comb begin
        if (is_div_q) begin
            add_x   = acc[63:31];
            add_y   = ~{1'b0, opb};
            add_cin = 1'b1;
        end else begin
            add_x   = {1'b0, acc[63:32]};
            add_y   = {1'b0, opb};
            add_cin = 1'b0;
        end
        add_sum = {1'b0, add_x} + {1'b0, add_y} + {33'd0, add_cin};

        if (is_div_q)
            acc_step = add_sum[33] ? {add_sum[31:0], acc[30:0], 1'b1}
                                   : {acc[62:0], 1'b0};
        else
            acc_step = acc[0] ? {add_sum[32:0], acc[31:1]}
                              : {1'b0, acc[63:1]};
    end

    // ------------------------------------------------------------ sign fix
    // A negative product is negated as a full 64-bit value so the high word
    // picks up the borrow out of the low word; quotient and remainder carry
    // independent signs and are negated on their own.
    logic [63:0] prod_neg;
    logic [31:0] part;
    logic [31:0] fix_val;

    always_comb begin
        prod_neg = 64'(-acc);
        part     = sel_hi_q ? acc[63:32] : acc[31:0];
        if (!neg_q)
            fix_val = part;
        else if (is_div_q)
            fix_val = 32'(-part);
        else
            fix_val = sel_hi_q ? prod_neg[63:32] : prod_neg[31:0];
    end

    // ----------------------------------------------------------------- FSM
    // NOTE: state is updated only with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the datapath registers are reset too, so nothing from an
            // aborted operation survives a reset.
            state       <= S_IDLE;
            step_cnt    <= '0;
            acc         <= '0;
            opb         <= '0;
            is_div_q    <= 1'b0;
            sel_hi_q    <= 1'b0;
            neg_q       <= 1'b0;
            dbz_q       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            div_by_zero <= 1'b0;
        end else if (flush) begin
            // Abort wins over everything, including a same-cycle start;
            // result and div_by_zero keep the last completed values.
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // The done cycle is spent in IDLE, so a start seen while
                    // done is high is refused until the following cycle.
                    if (start && dec.valid && !done) begin
                        state    <= S_CALC;
                        busy     <= 1'b1;
                        step_cnt <= '0;
                        is_div_q <= dec.is_div;
                        sel_hi_q <= dec.sel_hi;
                        neg_q    <= neg_next;
                        dbz_q    <= dec.is_div & b_zero;
                        if (dec.is_div) begin
                            acc <= {32'd0, mag_a};
                            opb <= mag_b;
                        end else begin
                            acc <= {32'd0, mag_b};
                            opb <= mag_a;
                        end
                    end
                end
                S_CALC: begin
                    acc      <= acc_step;
                    step_cnt <= step_cnt + 5'd1;
                    if (step_cnt == LAST_STEP)
                        state <= S_FIX;
                end
                S_FIX: begin
                    // Park the signed result in the low word until publish.
                    acc[31:0] <= fix_val;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    result      <= acc[31:0];
                    div_by_zero <= dbz_q;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// ----------------------------------------------------------------------------
// tb_muldiv_unit
// Scoreboard bench for muldiv_unit. The driver pushes the expected result,
// flag and acceptance cycle for every accepted request; an independent
// monitor pops and compares on each done pulse, including the latency.
// ----------------------------------------------------------------------------
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        div_by_zero;

    muldiv_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic        dbz;
        int          acc_cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad = 0;
    int          done_count = 0;
    logic [31:0] last_res = '0;
    logic        last_dbz = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model straight from the arithmetic definition of each op.
    function automatic void model(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic z);
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        logic signed [63:0] ps;
        logic signed [63:0] t;
        logic [63:0]        pu;
        sx = $signed(x);
        sy = $signed(y);
        ps = sx * sy;
        pu = {32'd0, x} * {32'd0, y};
        z  = 1'b0;
        r  = '0;
        case (o)
            ALU_OP_MUL:  r = ps[31:0];
            ALU_OP_MUH:  r = ps[63:32];
            ALU_OP_MULU: r = pu[31:0];
            ALU_OP_MUHU: r = pu[63:32];
            ALU_OP_DIV:  if (y == 0) begin r = '1; z = 1'b1; end
                         else begin t = sx / sy; r = t[31:0]; end
            ALU_OP_MOD:  if (y == 0) begin r = x; z = 1'b1; end
                         else begin t = sx % sy; r = t[31:0]; end
            ALU_OP_DIVU: if (y == 0) begin r = '1; z = 1'b1; end
                         else r = x / y;
            ALU_OP_MODU: if (y == 0) begin r = x; z = 1'b1; end
                         else r = x % y;
            default:     r = '0;
        endcase
    endfunction

    function automatic void expect_push(input logic [5:0] o, input logic [31:0] x,
                                        input logic [31:0] y, input int at);
        exp_t e;
        model(o, x, y, e.res, e.dbz);
        e.acc_cyc = at;
        sb_q.push_back(e);
        last_res = e.res;
        last_dbz = e.dbz;
    endfunction

    // ------------------------------------------------------------- monitor
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_count++;
            if (sb_q.size() == 0) begin
                check("unexpected_done", 64'(done), 64'(0));
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("result", 64'(result), 64'(e.res));
                check("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
                check("latency", 64'(cyc - e.acc_cyc), 64'(MDU_LATENCY));
            end
        end
    end

    // -------------------------------------------------------------- driver
    task automatic issue(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit expect_acc);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        if (expect_acc) expect_push(o, x, y, cyc);
    endtask

    task automatic drain();
        for (int i = 0; i < MDU_LATENCY + 10 && sb_q.size() != 0; i++) @(negedge clk);
        check("drain", 64'(sb_q.size()), 64'(0));
        @(negedge clk);
    endtask

    task automatic quiet(input string name, input int n);
        int snap;
        snap = done_count;
        repeat (n) @(negedge clk);
        check(name, 64'(done_count), 64'(snap));
    endtask

    logic [5:0] ops [8];

    initial begin
        #200000;
        $display("FAIL global_timeout: run did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        ops = '{ALU_OP_MUL, ALU_OP_MULU, ALU_OP_MUH, ALU_OP_MUHU,
                ALU_OP_DIV, ALU_OP_DIVU, ALU_OP_MOD, ALU_OP_MODU};
        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_result", 64'(result), 64'(0));
        check("reset_dbz", 64'(div_by_zero), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Directed corner cases.
        issue(ALU_OP_MUL,  32'hFFFFFFFE, 32'd3, 1);
        check("busy_after_accept", 64'(busy), 64'(1));
        drain();
        issue(ALU_OP_MUH,  32'hFFFFFFFE, 32'd3, 1);          drain();
        issue(ALU_OP_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);   drain();
        issue(ALU_OP_MUHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);   drain();
        issue(ALU_OP_DIV,  32'hFFFFFFF9, 32'd2, 1);          drain();
        issue(ALU_OP_MOD,  32'hFFFFFFF9, 32'd2, 1);          drain();
        issue(ALU_OP_DIVU, 32'd100, 32'd7, 1);               drain();
        issue(ALU_OP_MODU, 32'd100, 32'd7, 1);               drain();
        issue(ALU_OP_DIVU, 32'd5, 32'd0, 1);                 drain();
        issue(ALU_OP_MODU, 32'd5, 32'd0, 1);                 drain();
        issue(ALU_OP_DIV,  32'h80000000, 32'hFFFFFFFF, 1);   drain();
        issue(ALU_OP_MOD,  32'h80000000, 32'hFFFFFFFF, 1);   drain();
        issue(ALU_OP_DIV,  32'hFFFFFFF9, 32'd0, 1);          drain();
        issue(ALU_OP_MOD,  32'hFFFFFFF9, 32'd0, 1);          drain();
        issue(ALU_OP_MUL,  32'h80000000, 32'hFFFFFFFF, 1);   drain();

        // Unsupported op code is ignored.
        issue(6'h00, 32'd1, 32'd2, 0);
        check("bad_op_busy", 64'(busy), 64'(0));
        quiet("bad_op_no_done", 40);

        // Flush at cycle 10 of a multiply: no done, prior result kept.
        issue(ALU_OP_MUL, 32'd7, 32'd9, 0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'(0));
        quiet("flush_no_done", 40);
        check("flush_result_kept", 64'(result), 64'(last_res));
        check("flush_dbz_kept", 64'(div_by_zero), 64'(last_dbz));

        // Flush beats a same-cycle start.
        @(negedge clk);
        flush = 1'b1;
        start = 1'b1;
        op    = ALU_OP_MUL;
        a     = 32'd3;
        b     = 32'd4;
        @(negedge clk);
        flush = 1'b0;
        start = 1'b0;
        check("flush_start_busy", 64'(busy), 64'(0));
        quiet("flush_start_no_done", 40);

        // Start while busy is ignored.
        issue(ALU_OP_DIVU, 32'd1000, 32'd7, 1);
        repeat (5) @(negedge clk);
        start = 1'b1;
        op    = ALU_OP_MUL;
        a     = 32'd3;
        b     = 32'd3;
        @(negedge clk);
        start = 1'b0;
        drain();
        quiet("busy_start_no_extra_done", 40);

        // Start held through the done cycle: refused there, accepted next.
        issue(ALU_OP_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
        for (int i = 0; i < MDU_LATENCY + 10 && !done; i++) @(negedge clk);
        check("b2b_wait_done", 64'(done), 64'(1));
        start = 1'b1;
        op    = ALU_OP_MUHU;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        expect_push(ALU_OP_MUHU, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc);
        drain();

        // Reset at cycle 20 of a divide.
        issue(ALU_OP_DIV, 32'hFFFFFF00, 32'd3, 0);
        repeat (19) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_done", 64'(done), 64'(0));
        check("midrst_result", 64'(result), 64'(0));
        check("midrst_dbz", 64'(div_by_zero), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        quiet("midrst_no_done", 40);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            logic [31:0] x;
            logic [31:0] y;
            x = $urandom;
            case ($urandom_range(0, 4))
                0:       y = 32'd0;
                1:       y = $urandom_range(1, 15);
                2:       y = 32'hFFFFFFFF;
                default: y = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) x = $urandom_range(0, 100);
            issue(ops[$urandom_range(0, 7)], x, y, 1);
            drain();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
